// File: rtl/vsfx_pkg.sv
// ============================================================================
// Module : vsfx_pkg
// Brief  : Shared widths, writeback entry layout and FIFO fill-level encoding
//          for the vsfx writeback stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package vsfx_pkg;

  localparam int VEC_W    = 128;
  localparam int REG_AW   = 5;
  localparam int CR_W     = 4;
  localparam int WB_DEPTH = 2;

  // One buffered result: data plus the architectural side effects it carries.
  typedef struct packed {
    logic [VEC_W-1:0]  vrt;
    logic [REG_AW-1:0] addr;
    logic              sat;
    logic [CR_W-1:0]   cr6;
    logic              cr6_en;
  } vsfx_wb_entry_t;

  // Fill level of the two-entry writeback buffer.
  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_FULL  = 2'd2
  } wb_count_e;

endpackage

`default_nettype wire

// File: rtl/vsfx_wb_fifo.sv
// ============================================================================
// Module : vsfx_wb_fifo
// Brief  : Two-entry in-order result buffer: storage, 1-bit pointers, count.
//          Optional youngest-entry tap under VSFX_WB_BYPASS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vsfx_wb_fifo
  import vsfx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_i,
  input  logic              rdy_i,
  input  vsfx_wb_entry_t    din_i,
  output logic              in_ready_o,
  output logic              nonempty_o,
  output vsfx_wb_entry_t    head_o
`ifdef VSFX_WB_BYPASS_EN
  ,
  output logic [REG_AW-1:0] tail_addr_o,
  output logic [VEC_W-1:0]  tail_data_o
`endif
);

  wb_count_e      count_q, count_d;
  logic           wptr_q, rptr_q;
  logic           push, pop;
  vsfx_wb_entry_t mem_q [WB_DEPTH];

  // A full buffer refuses input even if it drains this cycle, keeping
  // in_ready a pure function of registered state.
  assign push       = vld_i & (count_q != CNT_FULL);
  assign pop        = rdy_i & (count_q != CNT_EMPTY);
  assign in_ready_o = (count_q != CNT_FULL);
  assign nonempty_o = (count_q != CNT_EMPTY);
  assign head_o     = mem_q[rptr_q];

`ifdef VSFX_WB_BYPASS_EN
  // Youngest entry sits one slot behind the write pointer.
  assign tail_addr_o = mem_q[~wptr_q].addr;
  assign tail_data_o = mem_q[~wptr_q].vrt;
`endif

  // Fill-level next state; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = (count_q == CNT_EMPTY) ? CNT_ONE : CNT_FULL;
      2'b01:   count_d = (count_q == CNT_FULL)  ? CNT_ONE : CNT_EMPTY;
      default: count_d = count_q;
    endcase
  end

  // Fill level and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= CNT_EMPTY;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) wptr_q <= ~wptr_q;
      if (pop)  rptr_q <= ~rptr_q;
    end
  end

  // Payload storage; cleared on reset so the write and bypass buses read zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WB_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wptr_q] <= din_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/vsfx_wb.sv
// ============================================================================
// Module : vsfx_wb
// Brief  : vsfx writeback stage: result buffer, register-file write port,
//          sticky VSCR[SAT], architected CR6, overflow flag, forwarding.
//          Build option: VSFX_WB_BYPASS_EN enables youngest-entry forwarding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vsfx_wb
  import vsfx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              vrt_en,
  input  logic [VEC_W-1:0]  vrt,
  input  logic              sat,
  input  logic [CR_W-1:0]   cr6,
  input  logic              cr6_en,
  input  logic [REG_AW-1:0] vrt_addr,
  output logic              in_ready,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_addr,
  output logic [VEC_W-1:0]  wr_data,
  input  logic              wr_ready,
  output logic              vscr_sat,
  input  logic              vscr_clr,
  output logic [CR_W-1:0]   cr6_q,
  output logic              ovf,
  output logic              byp_valid,
  output logic [REG_AW-1:0] byp_addr,
  output logic [VEC_W-1:0]  byp_data
);

  vsfx_wb_entry_t din, head;
  logic           pop;
  logic           vscr_sat_q, vscr_sat_d;
  logic [CR_W-1:0] cr6_arch_q, cr6_arch_d;
  logic           ovf_q, ovf_d;

`ifdef VSFX_WB_BYPASS_EN
  logic [REG_AW-1:0] tail_addr;
  logic [VEC_W-1:0]  tail_data;
`endif

  assign din = '{vrt: vrt, addr: vrt_addr, sat: sat, cr6: cr6, cr6_en: cr6_en};

  vsfx_wb_fifo u_fifo (
    .clk         (clk),
    .rst         (rst),
    .vld_i       (vrt_en),
    .rdy_i       (wr_ready),
    .din_i       (din),
    .in_ready_o  (in_ready),
    .nonempty_o  (wr_en),
    .head_o      (head)
`ifdef VSFX_WB_BYPASS_EN
    ,
    .tail_addr_o (tail_addr),
    .tail_data_o (tail_data)
`endif
  );

  assign wr_addr = head.addr;
  assign wr_data = head.vrt;
  assign pop     = wr_en & wr_ready;

  // Side effects of a result land only when it retires; a pop setting SAT
  // beats an mtvscr clear on the same edge.
  always_comb begin
    vscr_sat_d = vscr_sat_q;
    cr6_arch_d = cr6_arch_q;
    ovf_d      = ovf_q | (vrt_en & ~in_ready);
    if (vscr_clr)              vscr_sat_d = 1'b0;
    if (pop && head.sat)       vscr_sat_d = 1'b1;
    if (pop && head.cr6_en)    cr6_arch_d = head.cr6;
  end

  // Architected status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vscr_sat_q <= 1'b0;
      cr6_arch_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      vscr_sat_q <= vscr_sat_d;
      cr6_arch_q <= cr6_arch_d;
      ovf_q      <= ovf_d;
    end
  end

  assign vscr_sat = vscr_sat_q;
  assign cr6_q    = cr6_arch_q;
  assign ovf      = ovf_q;

`ifdef VSFX_WB_BYPASS_EN
  assign byp_valid = wr_en;
  assign byp_addr  = tail_addr;
  assign byp_data  = tail_data;
`else
  assign byp_valid = 1'b0;
  assign byp_addr  = '0;
  assign byp_data  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vsfx_wb.sv
// ============================================================================
// Module : tb_vsfx_wb
// Brief  : Self-checking bench for vsfx_wb (cycle table + write scoreboard).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vsfx_wb;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         vrt_en = 1'b0;
  logic [127:0] vrt = '0;
  logic         sat = 1'b0;
  logic [3:0]   cr6 = '0;
  logic         cr6_en = 1'b0;
  logic [4:0]   vrt_addr = '0;
  logic         in_ready, wr_en;
  logic [4:0]   wr_addr;
  logic [127:0] wr_data;
  logic         wr_ready = 1'b0;
  logic         vscr_sat;
  logic         vscr_clr = 1'b0;
  logic [3:0]   cr6_q;
  logic         ovf, byp_valid;
  logic [4:0]   byp_addr;
  logic [127:0] byp_data;

  vsfx_wb dut (
    .clk(clk), .rst(rst), .vrt_en(vrt_en), .vrt(vrt), .sat(sat), .cr6(cr6),
    .cr6_en(cr6_en), .vrt_addr(vrt_addr), .in_ready(in_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .vscr_sat(vscr_sat), .vscr_clr(vscr_clr), .cr6_q(cr6_q), .ovf(ovf),
    .byp_valid(byp_valid), .byp_addr(byp_addr), .byp_data(byp_data)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus plus the state expected after its rising edge.
  typedef struct {
    logic       en;   logic [4:0] addr; logic sat; logic [3:0] cr6;
    logic       c6en; logic wrr; logic clr; logic acc;
    logic       rdy;  logic wen; logic [4:0] waddr;
    logic       vs;   logic [3:0] c6; logic ov;
  } vec_t;

  typedef struct {
    logic [4:0]   a;
    logic [127:0] d;
  } wr_t;

  vec_t tbl [19];
  wr_t  sb [$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic logic [127:0] pay(input logic [4:0] a);
    return {8{11'h2A5, a}};
  endfunction

  function automatic vec_t mk(input logic en, input logic [4:0] addr,
      input logic s, input logic [3:0] c, input logic c6en, input logic wrr,
      input logic clr, input logic acc, input logic rdy, input logic wen,
      input logic [4:0] waddr, input logic vs, input logic [3:0] c6,
      input logic ov);
    vec_t v;
    v.en = en; v.addr = addr; v.sat = s; v.cr6 = c; v.c6en = c6en;
    v.wrr = wrr; v.clr = clr; v.acc = acc; v.rdy = rdy; v.wen = wen;
    v.waddr = waddr; v.vs = vs; v.c6 = c6; v.ov = ov;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Called at a falling edge: drive, score any write, clock, check state.
  task automatic cycle(input string nm, input vec_t v);
    wr_t e;
    vrt_en = v.en; vrt_addr = v.addr; vrt = pay(v.addr); sat = v.sat;
    cr6 = v.cr6; cr6_en = v.c6en; wr_ready = v.wrr; vscr_clr = v.clr;
    #1;
    if (wr_en && wr_ready) begin
      if (sb.size() == 0) begin
        chk({nm, "_unexpected_wr"}, {1'b1, wr_addr}, 6'd0);
      end else begin
        e = sb.pop_front();
        chk({nm, "_wr_addr"}, wr_addr, e.a);
        chk({nm, "_wr_data"}, wr_data, e.d);
      end
    end
    if (v.acc) begin
      e.a = v.addr; e.d = pay(v.addr);
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_in_ready"}, in_ready, v.rdy);
    chk({nm, "_wr_en"}, wr_en, v.wen);
    if (v.wen) chk({nm, "_head_addr"}, wr_addr, v.waddr);
    chk({nm, "_vscr_sat"}, vscr_sat, v.vs);
    chk({nm, "_cr6_q"}, cr6_q, v.c6);
    chk({nm, "_ovf"}, ovf, v.ov);
  endtask

  task automatic check_byp(input string nm, input logic [4:0] a);
`ifdef VSFX_WB_BYPASS_EN
    chk({nm, "_byp_valid"}, byp_valid, 1'b1);
    chk({nm, "_byp_addr"}, byp_addr, a);
    chk({nm, "_byp_data"}, byp_data, pay(a));
`else
    chk({nm, "_byp_valid"}, byp_valid, 1'b0);
    chk({nm, "_byp_addr"}, byp_addr, 5'd0);
    chk({nm, "_byp_data"}, byp_data, {95'd0, a} & 128'd0);
`endif
  endtask

  initial begin
    //            en a   s cr  c6 wr cl ac | rdy wen wa  vs c6 ov
    tbl[0]  = mk(1, 3,  0, 0, 0, 1, 0, 1,   1, 1, 3,  0, 0, 0); // single result
    tbl[1]  = mk(0, 0,  0, 0, 0, 1, 0, 0,   1, 0, 0,  0, 0, 0); // drained
    tbl[2]  = mk(1, 1,  0, 0, 0, 0, 0, 1,   1, 1, 1,  0, 0, 0); // stall: push 1
    tbl[3]  = mk(1, 2,  0, 0, 0, 0, 0, 1,   0, 1, 1,  0, 0, 0); // push 2 -> full
    tbl[4]  = mk(1, 4,  0, 0, 0, 0, 0, 0,   0, 1, 1,  0, 0, 1); // push 4 dropped
    tbl[5]  = mk(0, 0,  0, 0, 0, 1, 0, 0,   1, 1, 2,  0, 0, 1); // write 1
    tbl[6]  = mk(0, 0,  0, 0, 0, 1, 0, 0,   1, 0, 0,  0, 0, 1); // write 2
    tbl[7]  = mk(1, 7,  1, 0, 0, 0, 0, 1,   1, 1, 7,  0, 0, 1); // sat not at push
    tbl[8]  = mk(0, 0,  0, 0, 0, 1, 1, 0,   1, 0, 0,  1, 0, 1); // pop sat beats clr
    tbl[9]  = mk(0, 0,  0, 0, 0, 0, 1, 0,   1, 0, 0,  0, 0, 1); // clr alone
    tbl[10] = mk(1, 8,  0, 8, 1, 0, 0, 1,   1, 1, 8,  0, 0, 1); // cr6 not at push
    tbl[11] = mk(1, 9,  0, 2, 0, 1, 0, 1,   1, 1, 9,  0, 8, 1); // push+pop, cr6 load
    tbl[12] = mk(0, 0,  0, 0, 0, 1, 0, 0,   1, 0, 0,  0, 8, 1); // cr6 holds
    tbl[13] = mk(1, 10, 0, 0, 0, 0, 0, 1,   1, 1, 10, 0, 8, 1);
    tbl[14] = mk(1, 11, 0, 0, 0, 0, 0, 1,   0, 1, 10, 0, 8, 1);
    tbl[15] = mk(1, 12, 0, 0, 0, 1, 0, 0,   1, 1, 11, 0, 8, 1); // full+pop refuses
    tbl[16] = mk(0, 0,  0, 0, 0, 1, 0, 0,   1, 0, 0,  0, 8, 1);
    tbl[17] = mk(1, 20, 0, 0, 0, 0, 0, 1,   1, 1, 20, 0, 8, 1);
    tbl[18] = mk(1, 21, 0, 0, 0, 0, 0, 1,   0, 1, 20, 0, 8, 1); // full before reset

    // Reset state while rst is held.
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_wr_addr", wr_addr, 5'd0);
    chk("rst_wr_data", wr_data, 128'd0);
    chk("rst_vscr_sat", vscr_sat, 1'b0);
    chk("rst_cr6_q", cr6_q, 4'd0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_byp_valid", byp_valid, 1'b0);
    chk("rst_byp_addr", byp_addr, 5'd0);
    chk("rst_byp_data", byp_data, 128'd0);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) cycle($sformatf("v%0d", i), tbl[i]);

    // Asynchronous reset with two entries pending: takes effect before any edge.
    rst = 1'b1;
    #1;
    chk("arst_wr_en", wr_en, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_wr_data", wr_data, 128'd0);
    chk("arst_cr6_q", cr6_q, 4'd0);
    chk("arst_ovf", ovf, 1'b0);
    sb.delete();
    vrt_en = 1'b0; wr_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cycle("post_rst0", mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    cycle("post_rst1", mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    cycle("first_push", mk(1, 22, 0, 0, 0, 1, 0, 1, 1, 1, 22, 0, 0, 0));
    cycle("drain22", mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));

    // Forwarding of the youngest entry while writes are stalled.
    cycle("byp_push5", mk(1, 5, 0, 0, 0, 0, 0, 1, 1, 1, 5, 0, 0, 0));
    check_byp("byp5", 5'd5);
    cycle("byp_push6", mk(1, 6, 0, 0, 0, 0, 0, 1, 0, 1, 5, 0, 0, 0));
    check_byp("byp6", 5'd6);
    cycle("byp_drain0", mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 6, 0, 0, 0));
    cycle("byp_drain1", mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
